viterbi_acs_sched: RTL

Sequencer that time-shares a small bank of BMC/ACS butterfly units across all trellis states of the 64-state decoder. It accepts received symbol pairs over a valid/ready handshake. For each symbol it steps the butterfly bank through every state group and ping-pongs the path-metric (PM) banks. It also schedules PM normalization and hands completed frames to the traceback unit.
Sits between the input symbol FIFO and the BMC/ACS array, with traceback downstream.

---
 rtl/viterbi_pkg.sv | 25 ++
 rtl/viterbi_grp_counter.sv | 38 +++
 rtl/viterbi_acs_sched.sv | 138 +++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the 64-state Viterbi decoder datapath and its sequencing.
package viterbi_pkg;

  localparam int NUM_STATES = 64;
  localparam int NUM_UNITS  = 8;
  localparam int FRAME_W    = 12;
  localparam int G          = NUM_STATES / (2 * NUM_UNITS);
  localparam int GRP_W      = (G > 1) ? $clog2(G) : 1;
  localparam int PM_W       = 8;
  localparam int SURV_W     = 2 * NUM_UNITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SYM,
    ST_RUN,
    ST_COMMIT,
    ST_HANDOFF
  } state_t;

  // A zero frame length is treated as a single-symbol frame.
  function automatic logic [FRAME_W-1:0] last_index(input logic [FRAME_W-1:0] len);
    return (len == '0) ? '0 : len - FRAME_W'(1);
  endfunction

endpackage

// File: rtl/viterbi_grp_counter.sv
// Butterfly group counter with terminal-count flag; saturates at LAST instead of wrapping.
module viterbi_grp_counter
  import viterbi_pkg::*;
#(
  parameter int CNT_W = GRP_W,
  parameter int LAST  = G - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == CNT_W'(LAST));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/viterbi_acs_sched.sv
// Steps the shared ACS butterfly bank through all state groups per received symbol,
// ping-pongs PM banks, schedules normalization and hands finished frames to traceback.
module viterbi_acs_sched
  import viterbi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sym_valid,
  output logic               sym_ready,
  input  logic [1:0]         rx_pair_in,
  input  logic [FRAME_W-1:0] frame_len,
  output logic [1:0]         rx_pair_q,
  output logic [GRP_W-1:0]   grp_idx,
  output logic               acs_en,
  output logic               pm_rd_bank,
  output logic               surv_we,
  output logic [FRAME_W-1:0] surv_addr,
  input  logic               norm_req,
  output logic               norm_en,
  output logic               tb_start,
  input  logic               tb_busy,
  output logic               frame_done
);

  state_t             state_q;
  logic               sym_ready_q;
  logic [1:0]         rx_pair_r;
  logic               acs_en_q;
  logic               pm_rd_bank_q;
  logic               surv_we_q;
  logic [FRAME_W-1:0] surv_addr_q;
  logic [FRAME_W-1:0] last_idx_q;
  logic               norm_acc_q;
  logic               norm_en_q;
  logic               tb_start_q;
  logic               frame_done_q;
  logic               grp_tc;
  logic               accept;

  assign accept = (state_q == ST_WAIT_SYM) && sym_valid;

  viterbi_grp_counter #(
    .CNT_W (GRP_W),
    .LAST  (G - 1)
  ) u_grp_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept),
    .en_i  (state_q == ST_RUN),
    .cnt_o (grp_idx),
    .tc_o  (grp_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sym_ready_q  <= 1'b0;
      rx_pair_r    <= '0;
      acs_en_q     <= 1'b0;
      pm_rd_bank_q <= 1'b0;
      surv_we_q    <= 1'b0;
      surv_addr_q  <= '0;
      last_idx_q   <= '0;
      norm_acc_q   <= 1'b0;
      norm_en_q    <= 1'b0;
      tb_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      tb_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!tb_busy) begin
            state_q     <= ST_WAIT_SYM;
            sym_ready_q <= 1'b1;
            last_idx_q  <= last_index(frame_len);
            surv_addr_q <= '0;
          end
        end
        ST_WAIT_SYM: begin
          if (sym_valid) begin
            state_q     <= ST_RUN;
            sym_ready_q <= 1'b0;
            rx_pair_r   <= rx_pair_in;
            acs_en_q    <= 1'b1;
            surv_we_q   <= 1'b1;
            norm_acc_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          norm_acc_q <= norm_acc_q | norm_req;
          if (grp_tc) begin
            state_q   <= ST_COMMIT;
            acs_en_q  <= 1'b0;
            surv_we_q <= 1'b0;
          end
        end
        ST_COMMIT: begin
          // Bank swap and normalization take effect from the next symbol onward.
          pm_rd_bank_q <= ~pm_rd_bank_q;
          norm_en_q    <= norm_acc_q | norm_req;
          norm_acc_q   <= 1'b0;
          surv_addr_q  <= surv_addr_q + FRAME_W'(1);
          if (surv_addr_q == last_idx_q) begin
            state_q      <= ST_HANDOFF;
            tb_start_q   <= 1'b1;
            frame_done_q <= 1'b1;
          end else begin
            state_q     <= ST_WAIT_SYM;
            sym_ready_q <= 1'b1;
          end
        end
        ST_HANDOFF: begin
          if (!tb_busy) begin
            state_q     <= ST_WAIT_SYM;
            sym_ready_q <= 1'b1;
            last_idx_q  <= last_index(frame_len);
            surv_addr_q <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sym_ready  = sym_ready_q;
  assign rx_pair_q  = rx_pair_r;
  assign acs_en     = acs_en_q;
  assign pm_rd_bank = pm_rd_bank_q;
  assign surv_we    = surv_we_q;
  assign surv_addr  = surv_addr_q;
  assign norm_en    = norm_en_q;
  assign tb_start   = tb_start_q;
  assign frame_done = frame_done_q;

endmodule
